// File: rtl/mac1d_seq.sv
// mac1d_seq: sequenced dot-product engine, y = bias + sum(m[i]*x[i]), i = 0..VEC_LEN-1.
// A single combinational mac1d is reused every beat with the accumulator fed back as its b input.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   start_in, bias_in     begin a dot product (sampled in IDLE only); bias captured with start
//   m_in, x_in            weight / data element pair
//   in_valid, in_ready    input pair handshake
//   y_out, y_valid        result and its valid
//   y_ready               downstream accepts y_out
//   busy_out              high whenever the engine is not in IDLE
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start_in; outputs quiet
//   S_ACCUM | accepting element pairs, one MAC per accepted beat
//   S_DONE  | presenting the result until y_ready

// mac1d: y = b + m*x, all signed fixed point.
// Ports: m_in (Q IW_M.QW_M), x_in (Q IW_X.QW_X), b_in and y_out (Q IW_A.QW_A).
// The product is kept at full precision, aligned with b on a common binary point,
// summed with one guard integer bit, then floored to QW_A fraction bits and
// wrapped to IW_A integer bits.
module mac1d #(
  parameter int IW_M = 4,
  parameter int QW_M = 8,
  parameter int IW_X = 4,
  parameter int QW_X = 8,
  parameter int IW_A = 4,
  parameter int QW_A = 8
) (
  input  logic signed [IW_M+QW_M-1:0] m_in,
  input  logic signed [IW_X+QW_X-1:0] x_in,
  input  logic signed [IW_A+QW_A-1:0] b_in,
  output logic signed [IW_A+QW_A-1:0] y_out
);

  localparam int AW = IW_A + QW_A;
  localparam int PI = IW_M + IW_X;
  localparam int PQ = QW_M + QW_X;
  localparam int PW = PI + PQ;
  localparam int QF = (PQ > QW_A) ? PQ : QW_A;
  localparam int IF = ((PI > IW_A) ? PI : IW_A) + 1;
  localparam int SW = IF + QF;
  localparam int SH_P = QF - PQ;
  localparam int SH_A = QF - QW_A;

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] prod_al;
  logic signed [SW-1:0] acc_al;
  logic signed [SW-1:0] sum;

  assign prod    = PW'(m_in) * PW'(x_in);
  assign prod_al = SW'(prod) <<< SH_P;
  assign acc_al  = SW'(b_in) <<< SH_A;
  assign sum     = prod_al + acc_al;
  // Arithmetic shift floors the dropped fraction; the width cast then wraps the MSBs.
  assign y_out   = AW'(sum >>> SH_A);

endmodule

module mac1d_seq #(
  parameter int IW_M    = 4,
  parameter int QW_M    = 8,
  parameter int IW_X    = 4,
  parameter int QW_X    = 8,
  parameter int IW_A    = 4,
  parameter int QW_A    = 8,
  parameter int VEC_LEN = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic signed [IW_A+QW_A-1:0] bias_in,
  input  logic signed [IW_M+QW_M-1:0] m_in,
  input  logic signed [IW_X+QW_X-1:0] x_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [IW_A+QW_A-1:0] y_out,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        busy_out
);

  localparam int AW = IW_A + QW_A;
  localparam int CW = $clog2(VEC_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  mac_y;
  logic                  last_beat;

  mac1d #(
    .IW_M(IW_M), .QW_M(QW_M),
    .IW_X(IW_X), .QW_X(QW_X),
    .IW_A(IW_A), .QW_A(QW_A)
  ) u_mac (
    .m_in (m_in),
    .x_in (x_in),
    .b_in (acc_q),
    .y_out(mac_y)
  );

  assign last_beat = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_ACCUM;
          acc_d   = bias_in;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        // in_ready is constant 1 here, so in_valid alone marks an accepted beat.
        if (in_valid) begin
          acc_d = mac_y;
          if (last_beat) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        if (y_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode only the registered state
  always_comb begin
    in_ready = 1'b0;
    y_valid  = 1'b0;
    y_out    = '0;
    busy_out = (state_q != S_IDLE);
    case (state_q)
      S_ACCUM: in_ready = 1'b1;
      S_DONE: begin
        y_valid = 1'b1;
        y_out   = acc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac1d_seq.sv
module tb_mac1d_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // VEC_LEN = 4 instance
  logic        start, in_valid, in_ready, y_valid, y_ready, busy;
  logic [11:0] bias, m, x, y_out;

  // VEC_LEN = 1 instance
  logic        start_1, in_valid_1, in_ready_1, y_valid_1, y_ready_1, busy_1;
  logic [11:0] bias_1, m_1, x_1, y_out_1;

  mac1d_seq #(.VEC_LEN(4)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .bias_in(bias),
    .m_in(m), .x_in(x), .in_valid(in_valid), .in_ready(in_ready),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .busy_out(busy)
  );

  mac1d_seq #(.VEC_LEN(1)) dut_1 (
    .clk_in(clk), .rst_in(rst), .start_in(start_1), .bias_in(bias_1),
    .m_in(m_1), .x_in(x_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .y_out(y_out_1), .y_valid(y_valid_1), .y_ready(y_ready_1), .busy_out(busy_1)
  );

  int checks = 0;
  int failures = 0;

  logic [11:0] vm [4];
  logic [11:0] vx [4];
  int          gaps [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [11:0] m0, x0, m1, x1, m2, x2, m3, x3);
    vm[0] = m0; vx[0] = x0;
    vm[1] = m1; vx[1] = x1;
    vm[2] = m2; vx[2] = x2;
    vm[3] = m3; vx[3] = x3;
  endtask

  task automatic set_gaps(input int g0, g1, g2, g3);
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
  endtask

  // Runs one dot product on the VEC_LEN=4 instance and checks handshake,
  // latency, result, backpressure behaviour and return to IDLE.
  task automatic run_dot(input string tag, input logic [11:0] b,
                         input logic [11:0] exp_y, input int hold);
    int cyc;
    int gap_sum;
    gap_sum = 0;
    for (int i = 0; i < 4; i++) gap_sum += gaps[i];
    // start with a simultaneous in_valid: that pair must not be consumed
    start = 1'b1; bias = b; in_valid = 1'b1; m = 12'h7FF; x = 12'h7FF;
    tick();
    start = 1'b0; in_valid = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0; m = 12'h3A5; x = 12'h5C3;
        tick();
        cyc++;
      end
      if (i == 3) begin
        chk({tag, "_rdy_last"}, 32'(in_ready), 32'd1);
        chk({tag, "_yv_early"}, 32'(y_valid), 32'd0);
      end
      in_valid = 1'b1; m = vm[i]; x = vx[i];
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_yv"}, 32'(y_valid), 32'd1);
    chk({tag, "_y"}, 32'(y_out), 32'(exp_y));
    chk({tag, "_lat"}, 32'(cyc), 32'(5 + gap_sum));
    chk({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
    // backpressure with start and in_valid pushed at the engine
    y_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; in_valid = 1'b1; m = 12'h100; x = 12'h100; bias = 12'h123;
      tick();
      chk({tag, "_bp_yv"}, 32'(y_valid), 32'd1);
      chk({tag, "_bp_y"}, 32'(y_out), 32'(exp_y));
      chk({tag, "_bp_rdy"}, 32'(in_ready), 32'd0);
    end
    // handshake cycle, start still asserted and must be ignored
    y_ready = 1'b1; start = 1'b1; in_valid = 1'b0;
    tick();
    y_ready = 1'b0; start = 1'b0;
    chk({tag, "_idle_yv"}, 32'(y_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_idle_busy2"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; bias = 0; m = 0; x = 0; in_valid = 0; y_ready = 0;
    start_1 = 0; bias_1 = 0; m_1 = 0; x_1 = 0; in_valid_1 = 0; y_ready_1 = 0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_yv", 32'(y_valid), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_busy_1", 32'(busy_1), 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic sum, 0.5 + 1 + 1 - 0.25 + 0.25 = 2.5
    set_vec(12'h100, 12'h100, 12'h200, 12'h080, 12'hF00, 12'h040, 12'h080, 12'h080);
    set_gaps(0, 0, 0, 0);
    run_dot("t1", 12'h080, 12'h280, 0);

    // 2: products below one LSB floor away (positive) or to -1/256 (negative)
    set_vec(12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001);
    run_dot("t2a", 12'h000, 12'h000, 0);
    set_vec(12'hFFF, 12'h001, 12'hFFF, 12'h001, 12'hFFF, 12'h001, 12'hFFF, 12'h001);
    run_dot("t2b", 12'h000, 12'hFFC, 0);

    // 3: 7 + 2 wraps to -7
    set_vec(12'h200, 12'h100, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
    run_dot("t3", 12'h700, 12'h900, 0);

    // 4: valid pattern 1,0,0,1,1,0,1 with 5 cycles of backpressure
    set_vec(12'h100, 12'h100, 12'h200, 12'h080, 12'hF00, 12'h040, 12'h080, 12'h080);
    set_gaps(0, 2, 0, 1);
    run_dot("t4", 12'h080, 12'h280, 5);

    // 5: reset after two accepted beats, then a clean run
    set_gaps(0, 0, 0, 0);
    start = 1'b1; bias = 12'h080;
    tick();
    start = 1'b0;
    in_valid = 1'b1; m = 12'h100; x = 12'h100;
    tick();
    m = 12'h200; x = 12'h080;
    tick();
    in_valid = 1'b0;
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_rdy", 32'(in_ready), 32'd0);
    chk("t5_rst_yv", 32'(y_valid), 32'd0);
    chk("t5_rst_y", 32'(y_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("t5_idle", 32'(busy), 32'd0);
    run_dot("t5", 12'h080, 12'h280, 0);

    // 6: VEC_LEN=1, -0.0625 + 1*0.0625 = 0
    start_1 = 1'b1; bias_1 = 12'hFF0;
    tick();
    start_1 = 1'b0;
    chk("t6_rdy", 32'(in_ready_1), 32'd1);
    in_valid_1 = 1'b1; m_1 = 12'h100; x_1 = 12'h010;
    tick();
    in_valid_1 = 1'b0;
    chk("t6_yv", 32'(y_valid_1), 32'd1);
    chk("t6_y", 32'(y_out_1), 32'd0);
    chk("t6_rdy_done", 32'(in_ready_1), 32'd0);
    y_ready_1 = 1'b1;
    tick();
    y_ready_1 = 1'b0;
    chk("t6_idle", 32'(busy_1), 32'd0);
    chk("t6_yv_off", 32'(y_valid_1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
